// File: rtl/mesh_rx_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : mesh_rx_endpoint
// Purpose  : Receive endpoint for one 2x2-mesh processing node. It accepts an
//            armed burst from the router output_processor link into a local
//            first-word-fall-through FIFO. It also reports burst completion
//            and sticky link errors, and drives rx_ready as the node's
//            processor-ready path-free bit.
// Options  : RX_TIMEOUT_EN - when defined, an idle-cycle watchdog aborts a
//            stalled burst after TIMEOUT idle cycles (err_flags[2]).
// Revision : 1.0 - initial release
// ============================================================================
module mesh_rx_endpoint #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     arm,
  input  logic [7:0]               arm_len,
  input  logic [1:0]               arm_src,
  input  logic [9:0]               data_from_router,
  output logic                     rx_ready,
  input  logic                     rd_en,
  output logic [8:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     burst_done,
  output logic [1:0]               done_src,
  output logic [2:0]               err_flags,
  input  logic                     err_clr
);

  localparam int c_aw    = $clog2(DEPTH);
  localparam int c_cnt_w = c_aw + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         remaining_q, remaining_d;
  logic [1:0]         src_q, src_d;
  logic [1:0]         done_src_q, done_src_d;
  logic [2:0]         err_q, err_d;
  logic [c_aw-1:0]    wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]    rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic [8:0]         mem_q [DEPTH];

  logic w_valid;
  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_overflow;
  logic w_stray;
  logic w_timeout;
  logic w_to_hit;

  assign w_valid = data_from_router[9];
  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_cnt_w'(DEPTH));
  // A pop needs a resident word; rd_en on an empty FIFO does nothing.
  assign w_pop   = rd_en && !w_empty;

`ifdef RX_TIMEOUT_EN
  localparam int c_to_w = $clog2(TIMEOUT + 1);

  logic [c_to_w-1:0] idle_cnt_q, idle_cnt_d;

  // Count consecutive idle link cycles while receiving; any valid word or leaving RECV clears it.
  always_comb begin
    idle_cnt_d = '0;
    if (state_q == S_RECV && !w_valid) begin
      idle_cnt_d = idle_cnt_q + c_to_w'(1);
    end
  end

  // The idle cycle that brings the count to TIMEOUT aborts the burst.
  assign w_to_hit = (state_q == S_RECV) && !w_valid &&
                    (idle_cnt_q == c_to_w'(TIMEOUT - 1));

  // Idle counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT;
  assign w_to_hit         = 1'b0;
`endif

  // Burst FSM: next state, burst bookkeeping and error event detection.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    src_d       = src_q;
    done_src_d  = done_src_q;
    w_push      = 1'b0;
    w_overflow  = 1'b0;
    w_stray     = 1'b0;
    w_timeout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_valid) begin
          w_stray = 1'b1;
        end
        if (arm && arm_len != 8'd0) begin
          state_d     = S_RECV;
          remaining_d = arm_len;
          src_d       = arm_src;
        end
      end
      S_RECV: begin
        if (w_valid) begin
          // A full FIFO still takes the word when the same-cycle pop frees a slot.
          if (!w_full || rd_en) begin
            w_push = 1'b1;
          end else begin
            w_overflow = 1'b1;
          end
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_d    = S_DONE;
            done_src_d = src_q;
          end
        end else if (w_to_hit) begin
          w_timeout = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy update; push and pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (w_push ? c_aw'(1) : c_aw'(0));
    rd_ptr_d = rd_ptr_q + (w_pop  ? c_aw'(1) : c_aw'(0));
    count_d  = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_cnt_w'(1);
      2'b01:   count_d = count_q - c_cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky error flags; an event in the clearing cycle keeps its bit set.
  always_comb begin
    err_d = err_clr ? 3'b000 : err_q;
    err_d = err_d | {w_timeout, w_stray, w_overflow};
  end

  // State, pointer and flag registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= 8'd0;
      src_q       <= 2'd0;
      done_src_q  <= 2'd0;
      err_q       <= 3'b000;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      src_q       <= src_d;
      done_src_q  <= done_src_d;
      err_q       <= err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; stale entries are masked by the occupancy count, so no reset is needed.
  always_ff @(posedge clock) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= data_from_router[8:0];
    end
  end

  assign rx_ready   = (state_q == S_IDLE);
  assign burst_done = (state_q == S_DONE);
  assign done_src   = done_src_q;
  assign err_flags  = err_q;
  assign empty      = w_empty;
  assign full       = w_full;
  assign fifo_count = count_q;
  assign rd_data    = w_empty ? 9'd0 : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_mesh_rx_endpoint.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesh_rx_endpoint
// Purpose  : Self-checking bench for mesh_rx_endpoint (DEPTH=16, TIMEOUT=8).
//            It covers a directed vector table, multi-cycle corner sequences
//            and randomized traffic against a queue-based reference model.
//            It follows RX_TIMEOUT_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mesh_rx_endpoint;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 8;
`ifdef RX_TIMEOUT_EN
  localparam bit c_to_en = 1'b1;
`else
  localparam bit c_to_en = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       arm = 1'b0;
  logic [7:0] arm_len = 8'd0;
  logic [1:0] arm_src = 2'd0;
  logic [9:0] data_from_router = 10'd0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic       rx_ready;
  logic [8:0] rd_data;
  logic       empty;
  logic       full;
  logic [4:0] fifo_count;
  logic       burst_done;
  logic [1:0] done_src;
  logic [2:0] err_flags;

  int checks = 0;
  int failures = 0;

  mesh_rx_endpoint #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .arm(arm), .arm_len(arm_len), .arm_src(arm_src),
    .data_from_router(data_from_router), .rx_ready(rx_ready), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .fifo_count(fifo_count),
    .burst_done(burst_done), .done_src(done_src), .err_flags(err_flags),
    .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  // Reference model: a word queue plus the burst bookkeeping.
  logic [8:0] mq[$];
  int         m_mode;      // 0 idle, 1 receiving, 2 completion cycle
  int         m_rem;
  int         m_idle;
  logic [1:0] m_src;
  logic [1:0] m_done_src;
  logic [2:0] m_err;

  task automatic model_reset();
    mq.delete();
    m_mode = 0; m_rem = 0; m_idle = 0;
    m_src = 2'd0; m_done_src = 2'd0; m_err = 3'b000;
  endtask

  task automatic model_step(input logic a, input logic [7:0] l, input logic [1:0] s,
                            input logic [9:0] d, input logic rd, input logic clr);
    bit pop, push, ovf, stray, tmo;
    int nxt;
    pop = rd && (mq.size() > 0);
    push = 0; ovf = 0; stray = 0; tmo = 0;
    nxt = m_mode;
    if (m_mode == 0) begin
      if (d[9]) stray = 1;
      if (a && l != 0) begin
        nxt = 1; m_rem = int'(l); m_src = s; m_idle = 0;
      end
    end else if (m_mode == 1) begin
      if (d[9]) begin
        m_idle = 0;
        if (mq.size() < DEPTH || rd) push = 1; else ovf = 1;
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          nxt = 2; m_done_src = m_src;
        end
      end else begin
        m_idle = m_idle + 1;
        if (c_to_en && m_idle >= TIMEOUT) begin
          tmo = 1; nxt = 0;
        end
      end
    end else begin
      nxt = 0;
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(d[8:0]);
    if (clr) m_err = 3'b000;
    m_err = m_err | {tmo, stray, ovf};
    m_mode = nxt;
  endtask

  function automatic logic [22:0] act_vec();
    return {rx_ready, empty, full, fifo_count, rd_data, burst_done, done_src, err_flags};
  endfunction

  function automatic logic [22:0] model_vec();
    logic [8:0] head;
    head = (mq.size() > 0) ? mq[0] : 9'd0;
    return {(m_mode == 0), (mq.size() == 0), (mq.size() == DEPTH), 5'(mq.size()),
            head, (m_mode == 2), m_done_src, m_err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, advance, then compare every output against the model.
  task automatic cyc(input logic a, input logic [7:0] l, input logic [1:0] s,
                     input logic [9:0] d, input logic rd, input logic clr);
    arm = a; arm_len = l; arm_src = s; data_from_router = d; rd_en = rd; err_clr = clr;
    @(posedge clock);
    #1;
    model_step(a, l, s, d, rd, clr);
    check("model", 32'(act_vec()), 32'(model_vec()));
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 8'd0, 2'd0, 10'd0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset(input string name);
    arm = 0; arm_len = 0; arm_src = 0; data_from_router = 0; rd_en = 0; err_clr = 0;
    #2;
    reset = 1'b1;
    #1;
    check(name, 32'(act_vec()), 32'({1'b1, 1'b1, 1'b0, 5'd0, 9'd0, 1'b0, 2'd0, 3'b000}));
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic       a;
    logic [7:0] l;
    logic [1:0] s;
    logic [9:0] d;
    logic       rd;
    logic       clr;
    logic       rx;
    logic [4:0] cnt;
    logic [8:0] rdd;
    logic       bd;
    logic [1:0] ds;
    logic [2:0] err;
  } vec_t;

  vec_t tbl[19];

  initial begin
    logic [8:0] exp_word;
    logic [9:0] w;
    int         phase_dense;

    // a, len, src, din, rd, clr | rx, cnt, rd_data, bd, ds, err
    tbl[0]  = '{1'b1, 8'd4, 2'd2, 10'h000, 1'b0, 1'b0, 1'b0, 5'd0, 9'h000, 1'b0, 2'd0, 3'b000};
    tbl[1]  = '{1'b0, 8'd0, 2'd0, 10'h201, 1'b0, 1'b0, 1'b0, 5'd1, 9'h001, 1'b0, 2'd0, 3'b000};
    tbl[2]  = '{1'b0, 8'd0, 2'd0, 10'h202, 1'b0, 1'b0, 1'b0, 5'd2, 9'h001, 1'b0, 2'd0, 3'b000};
    tbl[3]  = '{1'b0, 8'd0, 2'd0, 10'h203, 1'b0, 1'b0, 1'b0, 5'd3, 9'h001, 1'b0, 2'd0, 3'b000};
    tbl[4]  = '{1'b0, 8'd0, 2'd0, 10'h204, 1'b0, 1'b0, 1'b0, 5'd4, 9'h001, 1'b1, 2'd2, 3'b000};
    tbl[5]  = '{1'b0, 8'd0, 2'd0, 10'h000, 1'b0, 1'b0, 1'b1, 5'd4, 9'h001, 1'b0, 2'd2, 3'b000};
    tbl[6]  = '{1'b0, 8'd0, 2'd0, 10'h000, 1'b1, 1'b0, 1'b1, 5'd3, 9'h002, 1'b0, 2'd2, 3'b000};
    tbl[7]  = '{1'b0, 8'd0, 2'd0, 10'h000, 1'b1, 1'b0, 1'b1, 5'd2, 9'h003, 1'b0, 2'd2, 3'b000};
    tbl[8]  = '{1'b0, 8'd0, 2'd0, 10'h000, 1'b1, 1'b0, 1'b1, 5'd1, 9'h004, 1'b0, 2'd2, 3'b000};
    tbl[9]  = '{1'b0, 8'd0, 2'd0, 10'h000, 1'b1, 1'b0, 1'b1, 5'd0, 9'h000, 1'b0, 2'd2, 3'b000};
    tbl[10] = '{1'b0, 8'd0, 2'd0, 10'h000, 1'b1, 1'b0, 1'b1, 5'd0, 9'h000, 1'b0, 2'd2, 3'b000};
    tbl[11] = '{1'b0, 8'd0, 2'd0, 10'h355, 1'b0, 1'b0, 1'b1, 5'd0, 9'h000, 1'b0, 2'd2, 3'b010};
    tbl[12] = '{1'b1, 8'd0, 2'd3, 10'h000, 1'b0, 1'b0, 1'b1, 5'd0, 9'h000, 1'b0, 2'd2, 3'b010};
    tbl[13] = '{1'b0, 8'd0, 2'd0, 10'h000, 1'b0, 1'b1, 1'b1, 5'd0, 9'h000, 1'b0, 2'd2, 3'b000};
    tbl[14] = '{1'b1, 8'd3, 2'd1, 10'h000, 1'b0, 1'b0, 1'b0, 5'd0, 9'h000, 1'b0, 2'd2, 3'b000};
    tbl[15] = '{1'b1, 8'd7, 2'd3, 10'h211, 1'b0, 1'b0, 1'b0, 5'd1, 9'h011, 1'b0, 2'd2, 3'b000};
    tbl[16] = '{1'b0, 8'd0, 2'd0, 10'h212, 1'b0, 1'b0, 1'b0, 5'd2, 9'h011, 1'b0, 2'd2, 3'b000};
    tbl[17] = '{1'b0, 8'd0, 2'd0, 10'h213, 1'b0, 1'b0, 1'b0, 5'd3, 9'h011, 1'b1, 2'd1, 3'b000};
    tbl[18] = '{1'b0, 8'd0, 2'd0, 10'h000, 1'b0, 1'b0, 1'b1, 5'd3, 9'h011, 1'b0, 2'd1, 3'b000};

    model_reset();
    do_reset("reset_state");

    // Directed table: basic burst, drain, stray word, zero-length and re-arm.
    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].a, tbl[i].l, tbl[i].s, tbl[i].d, tbl[i].rd, tbl[i].clr);
      check($sformatf("vec%0d", i), 32'(act_vec()),
            32'({tbl[i].rx, (tbl[i].cnt == 5'd0), (tbl[i].cnt == 5'd16), tbl[i].cnt,
                 tbl[i].rdd, tbl[i].bd, tbl[i].ds, tbl[i].err}));
    end

    // Reset after 2 of 5 words: immediate return to reset values, no completion pulse.
    cyc(1'b1, 8'd5, 2'd2, 10'h000, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 2'd0, 10'h231, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 2'd0, 10'h232, 1'b0, 1'b0);
    do_reset("mid_burst_reset");
    for (int i = 0; i < 4; i++) begin
      idle_cyc();
      check("no_done_after_reset", 32'(burst_done), 32'(0));
    end

    // Overflow: 20 words into a 16-deep FIFO with no pops.
    cyc(1'b1, 8'd20, 2'd3, 10'h000, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      w = 10'h200 | 10'(i);
      cyc(1'b0, 8'd0, 2'd0, w, 1'b0, 1'b0);
      if (i == 16) check("ovf_err_before", 32'(err_flags), 32'(3'b000));
      if (i == 17) check("ovf_err_set", 32'(err_flags), 32'(3'b001));
    end
    check("ovf_done", 32'({burst_done, done_src, full, fifo_count, err_flags}),
          32'({1'b1, 2'd3, 1'b1, 5'd16, 3'b001}));
    idle_cyc();
    check("ovf_rx_ready", 32'(rx_ready), 32'(1));

    // Push and pop together at full: count holds, no overflow, wrapped write lands last.
    cyc(1'b0, 8'd0, 2'd0, 10'h000, 1'b0, 1'b1);
    cyc(1'b1, 8'd2, 2'd0, 10'h000, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 2'd0, 10'h2AA, 1'b1, 1'b0);
    check("full_pp1", 32'({fifo_count, err_flags, rd_data}), 32'({5'd16, 3'b000, 9'h002}));
    cyc(1'b0, 8'd0, 2'd0, 10'h2AB, 1'b1, 1'b0);
    check("full_pp2", 32'({fifo_count, err_flags, rd_data, burst_done}),
          32'({5'd16, 3'b000, 9'h003, 1'b1}));
    for (int k = 0; k < 16; k++) begin
      exp_word = (k < 14) ? 9'(k + 3) : ((k == 14) ? 9'h0AA : 9'h0AB);
      check($sformatf("drain%0d", k), 32'(rd_data), 32'(exp_word));
      cyc(1'b0, 8'd0, 2'd0, 10'h000, 1'b1, 1'b0);
    end
    check("drained_empty", 32'({empty, fifo_count}), 32'({1'b1, 5'd0}));

    // Stalled burst: one of three words then idle link.
    do_reset("reset_before_timeout");
    cyc(1'b1, 8'd3, 2'd1, 10'h000, 1'b0, 1'b0);
    cyc(1'b0, 8'd0, 2'd0, 10'h221, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) idle_cyc();
    if (c_to_en) begin
      check("timeout_abort", 32'({rx_ready, err_flags, fifo_count, burst_done}),
            32'({1'b1, 3'b100, 5'd1, 1'b0}));
    end else begin
      check("no_timeout", 32'({rx_ready, err_flags, fifo_count}), 32'({1'b0, 3'b000, 5'd1}));
    end
    for (int i = 0; i < 3 * TIMEOUT; i++) idle_cyc();
    check("stall_final", 32'(rx_ready), c_to_en ? 32'(1) : 32'(0));

    // Randomized traffic against the model, alternating dense and sparse link phases.
    do_reset("reset_before_random");
    phase_dense = 1;
    for (int n = 0; n < 4000; n++) begin
      logic       ra;
      logic [7:0] rl;
      logic [9:0] rd_w;
      if (n % 96 == 0) phase_dense = int'($urandom_range(0, 1));
      ra = ($urandom_range(0, 7) == 0);
      rl = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 24));
      rd_w = {(phase_dense != 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0),
              9'($urandom)};
      cyc(ra, rl, 2'($urandom), rd_w, ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 39) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
